aes_key_expansion: RTL and testbench



---
 rtl/aes_key_expansion.sv | 214 +++++++++++++++++++++
 tb/tb_aes_key_expansion.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expansion.sv
// -----------------------------------------------------------------------------
// aes_key_expansion
// Iterative AES-128 key schedule. A start loads the cipher key into slot 0,
// then one round key per clock is derived and stored in slots 1..10 of an
// internal 11-entry buffer. The round controller reads keys back by index
// through a registered read port.
//
// Ports
//   clk         in   1    single clock, rising edge
//   rst         in   1    synchronous active-high reset
//   start       in   1    begin expansion of key_in (accepted in IDLE/DONE only)
//   key_in      in   128  cipher key, byte 0 = [127:120], word w0 = [127:96]
//   rd_idx      in   4    round key index to read (0..10, others read as 0)
//   round_key   out  128  registered buffer[rd_idx], one-cycle latency
//   busy        out  1    expansion in progress
//   keys_valid  out  1    all 11 round keys stored and stable
//   rk_valid    out  1    one-cycle strobe per slot write (stream build only)
//   rk_idx      out  4    index of the slot just written (stream build only)
//   rk_data     out  128  value of the slot just written (stream build only)
//
// Configuration
//   AES_KEYEXP_STREAM_EN  defined: rk_* mirror every slot write.
//                         undefined: rk_* are tied to 0, no stream registers.
// -----------------------------------------------------------------------------
module aes_key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [3:0]   rd_idx,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         keys_valid,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // ~b == 255-b: byte 0 sits at the top of the table
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_t         state_r;
  state_t         next_state_s;
  logic           load_s;
  logic           step_s;
  logic           last_s;
  logic [127:0]   w_r;
  logic [3:0]     rnd_r;
  logic [127:0]   buf_r [0:10];
  logic [127:0]   round_key_r;
  logic           busy_r;
  logic           keys_valid_r;
  logic [31:0]    t_s;
  logic [31:0]    nw0_s;
  logic [31:0]    nw1_s;
  logic [31:0]    nw2_s;
  logic [31:0]    nw3_s;
  logic [127:0]   next_key_s;

  // Next round key from the working register; RotWord is a byte rotate left.
  always_comb begin
    t_s        = sub_word({w_r[23:0], w_r[31:24]}) ^ {rcon(rnd_r), 24'h000000};
    nw0_s      = w_r[127:96] ^ t_s;
    nw1_s      = w_r[95:64]  ^ nw0_s;
    nw2_s      = w_r[63:32]  ^ nw1_s;
    nw3_s      = w_r[31:0]   ^ nw2_s;
    next_key_s = {nw0_s, nw1_s, nw2_s, nw3_s};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_state_s;
  end

  // FSM next state and load/step strobes; start is ignored while expanding.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    last_s       = (rnd_r == 4'd10);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_s       = 1'b1;
          next_state_s = ST_EXPAND;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_EXPAND: begin
        step_s = 1'b1;
        if (last_s) next_state_s = ST_DONE;
        else        next_state_s = ST_EXPAND;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Working register, round counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_r          <= 128'h0;
      rnd_r        <= 4'd0;
      busy_r       <= 1'b0;
      keys_valid_r <= 1'b0;
    end else if (load_s) begin
      w_r          <= key_in;
      rnd_r        <= 4'd1;
      busy_r       <= 1'b1;
      keys_valid_r <= 1'b0;
    end else if (step_s) begin
      w_r   <= next_key_s;
      rnd_r <= rnd_r + 4'd1;
      if (last_s) begin
        busy_r       <= 1'b0;
        keys_valid_r <= 1'b1;
      end
    end
  end

  // Round key buffer; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && load_s)      buf_r[0]     <= key_in;
    else if (!rst && step_s) buf_r[rnd_r] <= next_key_s;
  end

  // Registered read port; out-of-range indices read as zero.
  always_ff @(posedge clk) begin
    if (rst)                  round_key_r <= 128'h0;
    else if (rd_idx <= 4'd10) round_key_r <= buf_r[rd_idx];
    else                      round_key_r <= 128'h0;
  end

  assign round_key  = round_key_r;
  assign busy       = busy_r;
  assign keys_valid = keys_valid_r;

`ifdef AES_KEYEXP_STREAM_EN
  logic         rk_valid_r;
  logic [3:0]   rk_idx_r;
  logic [127:0] rk_data_r;

  // Stream mirror of each slot write, one cycle after the write edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_valid_r <= 1'b0;
      rk_idx_r   <= 4'd0;
      rk_data_r  <= 128'h0;
    end else if (load_s) begin
      rk_valid_r <= 1'b1;
      rk_idx_r   <= 4'd0;
      rk_data_r  <= key_in;
    end else if (step_s) begin
      rk_valid_r <= 1'b1;
      rk_idx_r   <= rnd_r;
      rk_data_r  <= next_key_s;
    end else begin
      rk_valid_r <= 1'b0;
    end
  end

  assign rk_valid = rk_valid_r;
  assign rk_idx   = rk_idx_r;
  assign rk_data  = rk_data_r;
`else
  assign rk_valid = 1'b0;
  assign rk_idx   = 4'd0;
  assign rk_data  = 128'h0;
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expansion
// Self-checking bench for aes_key_expansion. The reference model builds the
// S-box from GF(2^8) inversion plus the affine map and runs the word-wise
// key schedule w[i] = w[i-4] ^ f(w[i-1]) over 44 words. Known FIPS-197
// vectors are checked as constants alongside random keys.
// -----------------------------------------------------------------------------
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [3:0]   rd_idx;
  logic [127:0] round_key;
  logic         busy;
  logic         keys_valid;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] MIXCOL_C1_R1 = 128'h5f72641557f5bc92f7be3b291db9f91a;

  int           check_cnt = 0;
  int           error_cnt = 0;
  logic [7:0]   sb_tab [0:255];
  logic [127:0] exp_rk [0:10];
  int           log_idx [$];
  logic [127:0] log_data [$];

  aes_key_expansion dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .rd_idx     (rd_idx),
    .round_key  (round_key),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_valid   (rk_valid),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data)
  );

  always #5 clk = ~clk;

  // Stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rk_valid) begin
      log_idx.push_back(int'(rk_idx));
      log_data.push_back(rk_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_exp(input logic [127:0] k, output int base);
    start  = 1'b1;
    key_in = k;
    tick();
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    base   = log_idx.size();
    check_eq("start_busy", 128'(busy), 128'(1));
    check_eq("start_kv_low", 128'(keys_valid), 128'(0));
  endtask

  task automatic wait_kv(input int exp_edges);
    int n = 0;
    while (!keys_valid && n < 30) begin
      tick();
      n++;
    end
    check_eq("kv_latency", 128'(n), 128'(exp_edges));
    check_eq("busy_after_done", 128'(busy), 128'(0));
  endtask

  task automatic read_chk(input string tag, input int idx, input logic [127:0] exp);
    rd_idx = 4'(idx);
    tick();
    check_eq(tag, round_key, exp);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++)
      read_chk(tag, i, (i <= 10) ? exp_rk[i] : 128'h0);
  endtask

  task automatic stream_chk(input int base);
`ifdef AES_KEYEXP_STREAM_EN
    check_eq("stream_count", 128'(log_idx.size() - base), 128'(11));
    for (int j = 0; j < 11; j++) begin
      if (base + j < log_idx.size()) begin
        check_eq("stream_idx", 128'(log_idx[base + j]), 128'(j));
        check_eq("stream_data", log_data[base + j], exp_rk[j]);
      end
    end
`else
    check_eq("stream_quiet", 128'(log_idx.size() - base), 128'(0));
`endif
  endtask

  initial begin
    int base;
    logic [127:0] ka;
    logic [127:0] kb;

    build_sbox();
    rst    = 1'b1;
    start  = 1'b0;
    key_in = 128'h0;
    rd_idx = 4'd0;
    tick();
    tick();
    check_eq("rst_round_key", round_key, 128'h0);
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_kv", 128'(keys_valid), 128'(0));
    check_eq("rst_rk_valid", 128'(rk_valid), 128'(0));
    check_eq("rst_rk_idx", 128'(rk_idx), 128'(0));
    check_eq("rst_rk_data", rk_data, 128'h0);
    rst = 1'b0;
    tick();

    // FIPS-197 C.1 key plus round-1 AddRoundKey chain
    model_expand(KEY_C1);
    start_exp(KEY_C1, base);
    wait_kv(10);
    read_chk("c1_idx1", 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check_eq("c1_addroundkey", round_key ^ MIXCOL_C1_R1, 128'h89d810e8855ace682d1843d8cb128fe4);
    read_chk("c1_idx10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    read_all("c1_model");
    stream_chk(base);

    // FIPS-197 A.1 key
    model_expand(KEY_A1);
    start_exp(KEY_A1, base);
    wait_kv(10);
    read_chk("a1_idx1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_chk("a1_idx10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_chk("a1_idx0", 0, KEY_A1);
    read_chk("a1_idx11", 11, 128'h0);
    read_chk("a1_idx15", 15, 128'h0);
    read_all("a1_model");
    stream_chk(base);

    // start during EXPAND (edge T+4) is ignored
    model_expand(KEY_C1);
    start_exp(KEY_C1, base);
    tick();
    tick();
    tick();
    start  = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start  = 1'b0;
    wait_kv(6);
    read_chk("ign_idx1", 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    read_chk("ign_idx10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    read_all("ign_model");
    stream_chk(base);

    // reset asserted at edge T+5, then a fresh expansion
    start_exp({$urandom, $urandom, $urandom, $urandom}, base);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_busy", 128'(busy), 128'(0));
    check_eq("midrst_kv", 128'(keys_valid), 128'(0));
    check_eq("midrst_round_key", round_key, 128'h0);
    check_eq("midrst_rk_valid", 128'(rk_valid), 128'(0));
    tick();
    tick();
    check_eq("midrst_idle_busy", 128'(busy), 128'(0));
    check_eq("midrst_idle_kv", 128'(keys_valid), 128'(0));
    ka = {$urandom, $urandom, $urandom, $urandom};
    model_expand(ka);
    start_exp(ka, base);
    wait_kv(10);
    read_all("postrst_model");
    stream_chk(base);

    // random keys, second start in the first DONE cycle
    for (int it = 0; it < 3; it++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      start_exp(ka, base);
      wait_kv(10);
      model_expand(kb);
      start_exp(kb, base);
      wait_kv(10);
      read_all("rand_model");
      stream_chk(base);
    end

`ifndef AES_KEYEXP_STREAM_EN
    check_eq("stream_never", 128'(log_idx.size()), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
